river_platform_scanner: RTL and testbench



---
 rtl/river_platform_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_river_platform_scanner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/river_platform_scanner.sv
// river_platform_scanner: finds the platform the frog is standing on.
// After a start strobe it checks NUM_PLAT platforms, one per frame_clk cycle. It reports the
// first (lowest-index) platform under the frog's probe points. It also reports river water
// contact and a debounced drown flag.
// Ports: frame_clk/Reset_n (async active-low); start, frog_x/frog_y (frog position);
//   plat_x/plat_y/plat_class/plat_valid/plat_vx (packed per-platform data, stable while busy);
//   busy/done (scan status); on_class/hit_idx/water/drown/ride_dx (results, held between done pulses).
// Optional feature macro RIDE_VEL_EN: ride_dx reports the winning platform's plat_vx.
//   Without the macro, ride_dx is 0.
module river_platform_scanner #(
  parameter int NUM_PLAT  = 14,
  parameter int IDX_W     = 6,
  parameter int LAND_Y    = 230,
  parameter int PROBE_L   = 2,
  parameter int PROBE_R   = 13,
  parameter int PROBE_Y   = 8,
  parameter int PLAT_H    = 16,
  parameter int DROWN_CNT = 3
) (
  input  logic                    frame_clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [9:0]              frog_x,
  input  logic [9:0]              frog_y,
  input  logic [10*NUM_PLAT-1:0]  plat_x,
  input  logic [10*NUM_PLAT-1:0]  plat_y,
  input  logic [2*NUM_PLAT-1:0]   plat_class,
  input  logic [NUM_PLAT-1:0]     plat_valid,
  input  logic [4*NUM_PLAT-1:0]   plat_vx,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              on_class,
  output logic [IDX_W-1:0]        hit_idx,
  output logic                    water,
  output logic                    drown,
  output logic [3:0]              ride_dx
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESOLVE, S_LAND} state_e;

  state_e           state_q, state_d;
  logic [9:0]       fx_q, fx_d, fy_q, fy_d;
  logic [IDX_W-1:0] idx_q, idx_d, win_idx_q, win_idx_d;
  logic             found_q, found_d;
  logic [1:0]       win_cls_q, win_cls_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       on_class_q, on_class_d;
  logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
  logic             water_q, water_d, drown_q, drown_d;

  // Platform currently under inspection.
  logic [9:0]  cur_x, cur_y;
  logic [1:0]  cur_cls;
  logic        cur_vld;
  assign cur_x   = plat_x[10*int'(idx_q) +: 10];
  assign cur_y   = plat_y[10*int'(idx_q) +: 10];
  assign cur_cls = plat_class[2*int'(idx_q) +: 2];
  assign cur_vld = plat_valid[int'(idx_q) +: 1];

  // The frog probes and the platform edges are computed with 11 bits, so no sum wraps around.
  logic [10:0] p_l, p_r, p_y, el_off, er_off, e_l, e_r, y_hi;
  logic        cur_hit;
  always_comb begin
    unique case (cur_cls)
      2'd0:    begin el_off = 11'd4; er_off = 11'd43; end
      2'd1:    begin el_off = 11'd4; er_off = 11'd59; end
      2'd2:    begin el_off = 11'd1; er_off = 11'd28; end
      default: begin el_off = 11'd1; er_off = 11'd44; end
    endcase
  end
  assign p_l  = {1'b0, fx_q} + 11'(PROBE_L);
  assign p_r  = {1'b0, fx_q} + 11'(PROBE_R);
  assign p_y  = {1'b0, fy_q} + 11'(PROBE_Y);
  assign e_l  = {1'b0, cur_x} + el_off;
  assign e_r  = {1'b0, cur_x} + er_off;
  assign y_hi = {1'b0, cur_y} + 11'(PLAT_H - 1);
  assign cur_hit = cur_vld
                && (((p_l >= e_l) && (p_l <= e_r)) || ((p_r >= e_l) && (p_r <= e_r)))
                && (p_y >= {1'b0, cur_y}) && (p_y <= y_hi);

`ifdef RIDE_VEL_EN
  logic [3:0] win_vx_q, win_vx_d, ride_q, ride_d, cur_vx;
  assign cur_vx  = plat_vx[4*int'(idx_q) +: 4];
  assign ride_dx = ride_q;
`else
  logic unused_vx;
  assign unused_vx = ^plat_vx;
  assign ride_dx   = 4'b0000;
`endif

  always_comb begin
    state_d    = state_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    idx_d      = idx_q;
    found_d    = found_q;
    win_idx_d  = win_idx_q;
    win_cls_d  = win_cls_q;
    cnt_d      = cnt_q;
    on_class_d = on_class_q;
    hit_idx_d  = hit_idx_q;
    water_d    = water_q;
    drown_d    = drown_q;
`ifdef RIDE_VEL_EN
    win_vx_d   = win_vx_q;
    ride_d     = ride_q;
`endif
    busy = (state_q != S_IDLE);
    done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fx_d = frog_x;
          fy_d = frog_y;
          if (frog_y >= 10'(LAND_Y)) begin
            // The land results are loaded while entering LAND, so they are valid during done.
            state_d    = S_LAND;
            on_class_d = 4'b0000;
            hit_idx_d  = '0;
            water_d    = 1'b0;
            cnt_d      = 4'd0;
            drown_d    = 1'b0;
`ifdef RIDE_VEL_EN
            ride_d     = 4'b0000;
`endif
          end else begin
            state_d = S_SCAN;
            idx_d   = '0;
            found_d = 1'b0;
          end
        end
      end
      S_SCAN: begin
        if (cur_hit && !found_q) begin
          found_d   = 1'b1;
          win_idx_d = idx_q;
          win_cls_d = cur_cls;
`ifdef RIDE_VEL_EN
          win_vx_d  = cur_vx;
`endif
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(NUM_PLAT - 1)) begin
          // The final result includes the last platform. It is registered while entering
          // RESOLVE, so the outputs change together with the rising edge of done.
          state_d    = S_RESOLVE;
          water_d    = !found_d;
          on_class_d = found_d ? (4'b0001 << win_cls_d) : 4'b0000;
          hit_idx_d  = found_d ? win_idx_d : '0;
          if (found_d)
            cnt_d = 4'd0;
          else if (cnt_q != 4'(DROWN_CNT))
            cnt_d = cnt_q + 4'd1;
          drown_d    = (cnt_d == 4'(DROWN_CNT));
`ifdef RIDE_VEL_EN
          ride_d     = found_d ? win_vx_d : 4'b0000;
`endif
        end
      end
      S_RESOLVE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_LAND: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      fx_q       <= '0;
      fy_q       <= '0;
      idx_q      <= '0;
      found_q    <= 1'b0;
      win_idx_q  <= '0;
      win_cls_q  <= '0;
      cnt_q      <= '0;
      on_class_q <= '0;
      hit_idx_q  <= '0;
      water_q    <= 1'b0;
      drown_q    <= 1'b0;
`ifdef RIDE_VEL_EN
      win_vx_q   <= '0;
      ride_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      idx_q      <= idx_d;
      found_q    <= found_d;
      win_idx_q  <= win_idx_d;
      win_cls_q  <= win_cls_d;
      cnt_q      <= cnt_d;
      on_class_q <= on_class_d;
      hit_idx_q  <= hit_idx_d;
      water_q    <= water_d;
      drown_q    <= drown_d;
`ifdef RIDE_VEL_EN
      win_vx_q   <= win_vx_d;
      ride_q     <= ride_d;
`endif
    end
  end

  assign on_class = on_class_q;
  assign hit_idx  = hit_idx_q;
  assign water    = water_q;
  assign drown    = drown_q;

endmodule

// File: tb/tb_river_platform_scanner.sv
module tb_river_platform_scanner;
  localparam int NP = 14;
  localparam int IW = 6;
  localparam int DROWN = 3;

  logic              frame_clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              start = 1'b0;
  logic [9:0]        frog_x = '0, frog_y = '0;
  logic [10*NP-1:0]  plat_x, plat_y;
  logic [2*NP-1:0]   plat_class;
  logic [NP-1:0]     plat_valid;
  logic [4*NP-1:0]   plat_vx;
  logic              busy, done, water, drown;
  logic [3:0]        on_class, ride_dx;
  logic [IW-1:0]     hit_idx;

  river_platform_scanner dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .start(start),
    .frog_x(frog_x), .frog_y(frog_y),
    .plat_x(plat_x), .plat_y(plat_y), .plat_class(plat_class),
    .plat_valid(plat_valid), .plat_vx(plat_vx),
    .busy(busy), .done(done), .on_class(on_class), .hit_idx(hit_idx),
    .water(water), .drown(drown), .ride_dx(ride_dx)
  );

  always #5 frame_clk = ~frame_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: platform table, drown counter and predicted/held results.
  int px[NP], py[NP], pc[NP], pv[NP], pvx[NP];
  int wcnt = 0;
  int pred_cls, pred_idx, pred_water, pred_drown, pred_ride, pred_lat;
  int exp_cls = 0, exp_idx = 0, exp_water = 0, exp_drown = 0, exp_ride = 0;
  bit chk_en = 1'b0;

  task automatic apply_plats();
    for (int i = 0; i < NP; i++) begin
      plat_x[10*i +: 10]   = 10'(px[i]);
      plat_y[10*i +: 10]   = 10'(py[i]);
      plat_class[2*i +: 2] = 2'(pc[i]);
      plat_valid[i]        = (pv[i] != 0);
      plat_vx[4*i +: 4]    = 4'(pvx[i]);
    end
  endtask

  task automatic clear_plats();
    for (int i = 0; i < NP; i++) begin
      px[i] = 800; py[i] = 900; pc[i] = 0; pv[i] = 1; pvx[i] = 0;
    end
    apply_plats();
  endtask

  task automatic set_plat(input int i, input int x, input int y, input int c, input int vx);
    px[i] = x; py[i] = y; pc[i] = c; pv[i] = 1; pvx[i] = vx;
    apply_plats();
  endtask

  task automatic predict(input int fx, input int fy);
    int pl, pr, pyy, el, er, win;
    if (fy >= 230) begin
      pred_lat = 1; pred_cls = 0; pred_idx = 0; pred_water = 0; pred_ride = 0;
      wcnt = 0;
    end else begin
      pred_lat = NP + 1;
      pl = fx + 2; pr = fx + 13; pyy = fy + 8;
      win = -1;
      for (int i = NP - 1; i >= 0; i--) begin
        el = (pc[i] <= 1) ? 4 : 1;
        er = (pc[i] == 0) ? 43 : (pc[i] == 1) ? 59 : (pc[i] == 2) ? 28 : 44;
        if (pv[i] != 0 && ((pl >= px[i] + el && pl <= px[i] + er) ||
                           (pr >= px[i] + el && pr <= px[i] + er)) &&
            pyy >= py[i] && pyy <= py[i] + 15)
          win = i;
      end
      if (win < 0) begin
        pred_cls = 0; pred_idx = 0; pred_water = 1; pred_ride = 0;
        wcnt = (wcnt < DROWN) ? wcnt + 1 : DROWN;
      end else begin
        pred_cls = 1 << pc[win]; pred_idx = win; pred_water = 0;
`ifdef RIDE_VEL_EN
        pred_ride = pvx[win] & 15;
`else
        pred_ride = 0;
`endif
        wcnt = 0;
      end
    end
    pred_drown = (wcnt == DROWN) ? 1 : 0;
  endtask

  // Compare process: on done the outputs must show the prediction; otherwise they must hold.
  always @(negedge frame_clk) begin
    if (Reset_n && chk_en) begin
      if (done) begin
        chk("on_class", on_class, pred_cls);
        chk("hit_idx", hit_idx, pred_idx);
        chk("water", water, pred_water);
        chk("drown", drown, pred_drown);
        chk("ride_dx", ride_dx, pred_ride);
        exp_cls = pred_cls; exp_idx = pred_idx; exp_water = pred_water;
        exp_drown = pred_drown; exp_ride = pred_ride;
      end else begin
        chk("hold_on_class", on_class, exp_cls);
        chk("hold_hit_idx", hit_idx, exp_idx);
        chk("hold_water", water, exp_water);
        chk("hold_drown", drown, exp_drown);
        chk("hold_ride_dx", ride_dx, exp_ride);
      end
    end
  end

  task automatic run_scan(input int fx, input int fy, input int l_idx, input int l_cls,
                          input int l_water, input int l_drown, input bit extra);
    int ndone, first;
    predict(fx, fy);
    chk("model_idx", pred_idx, l_idx);
    chk("model_cls", pred_cls, l_cls);
    chk("model_water", pred_water, l_water);
    chk("model_drown", pred_drown, l_drown);
    @(negedge frame_clk);
    frog_x = 10'(fx); frog_y = 10'(fy); start = 1'b1;
    @(posedge frame_clk);
    @(negedge frame_clk);
    start = 1'b0;
    ndone = 0; first = -1;
    for (int k = 1; k <= pred_lat + 4; k++) begin
      if (k <= pred_lat) chk("busy_high", busy, 1);
      if (done) begin
        ndone++;
        if (first < 0) first = k;
      end
      start = (extra && k == 3);
      @(negedge frame_clk);
    end
    chk("latency", first, pred_lat);
    chk("done_pulses", ndone, 1);
    chk("busy_low_after", busy, 0);
  endtask

  initial begin
    int ndone;
    clear_plats();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_on_class", on_class, 0);
    chk("rst_hit_idx", hit_idx, 0);
    chk("rst_water", water, 0);
    chk("rst_drown", drown, 0);
    chk("rst_ride_dx", ride_dx, 0);
    @(negedge frame_clk);
    Reset_n = 1'b1;
    chk_en = 1'b1;

    // Land path.
    run_scan(100, 240, 0, 0, 0, 0, 0);
    // Single log under the frog.
    set_plat(3, 95, 100, 0, 0);
    run_scan(100, 100, 3, 1, 0, 0, 0);
    // Lowest index wins; a submerged platform is skipped.
    clear_plats();
    set_plat(2, 95, 100, 3, 0);
    set_plat(5, 90, 100, 1, 0);
    run_scan(100, 100, 2, 8, 0, 0, 0);
    pv[2] = 0; apply_plats();
    run_scan(100, 100, 5, 2, 0, 0, 0);
    clear_plats();
    set_plat(7, 100, 100, 2, 0);
    run_scan(100, 100, 7, 4, 0, 0, 0);
    // Water debounce, saturation and clear.
    clear_plats();
    run_scan(100, 100, 0, 0, 1, 0, 0);
    run_scan(100, 100, 0, 0, 1, 0, 0);
    run_scan(100, 100, 0, 0, 1, 1, 0);
    run_scan(100, 100, 0, 0, 1, 1, 0);
    set_plat(0, 95, 100, 0, 0);
    run_scan(100, 100, 0, 1, 0, 0, 0);
    // X and Y edges of a log at (100,100): X window [104,143], Y window [100,115].
    clear_plats();
    set_plat(9, 100, 100, 0, 0);
    run_scan(89, 100, 0, 0, 1, 0, 0);
    run_scan(90, 100, 0, 0, 1, 0, 0);
    run_scan(91, 100, 9, 1, 0, 0, 0);
    run_scan(141, 100, 9, 1, 0, 0, 0);
    run_scan(142, 100, 0, 0, 1, 0, 0);
    run_scan(100, 107, 9, 1, 0, 0, 0);
    run_scan(100, 108, 0, 0, 1, 0, 0);
    run_scan(100, 92, 9, 1, 0, 0, 0);
    run_scan(100, 91, 0, 0, 1, 0, 0);
    // A start issued while busy is ignored.
    clear_plats();
    set_plat(3, 95, 100, 0, 0);
    run_scan(100, 100, 3, 1, 0, 0, 1);
    // Ride velocity of the winner; a later covering platform is ignored.
    clear_plats();
    set_plat(4, 95, 100, 0, -3);
    set_plat(6, 90, 100, 1, 5);
    run_scan(100, 100, 4, 1, 0, 0, 0);
`ifdef RIDE_VEL_EN
    chk("model_ride", pred_ride, 13);
`endif
    clear_plats();
    run_scan(100, 100, 0, 0, 1, 0, 0);
    // Reset in the middle of a scan: outputs clear immediately and no done pulse follows.
    set_plat(3, 95, 100, 0, 0);
    @(negedge frame_clk);
    frog_x = 10'd100; frog_y = 10'd100; start = 1'b1;
    @(posedge frame_clk);
    @(negedge frame_clk);
    start = 1'b0;
    repeat (4) @(negedge frame_clk);
    Reset_n = 1'b0;
    exp_cls = 0; exp_idx = 0; exp_water = 0; exp_drown = 0; exp_ride = 0;
    wcnt = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_on_class", on_class, 0);
    chk("abort_hit_idx", hit_idx, 0);
    chk("abort_water", water, 0);
    chk("abort_drown", drown, 0);
    repeat (2) @(negedge frame_clk);
    Reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge frame_clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", busy, 0);
    // The scanner must still work normally after the abort.
    run_scan(100, 100, 3, 1, 0, 0, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
